fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage. It sits directly upstream of the control unit and feeds it op/funct3/funct7 plus the full instruction word. It consumes pcSrc from the control unit as its redirect input.
It owns the PC register, issues variable-latency requests to instruction memory, and buffers returned words in a small in-order FIFO. It presents them downstream with a valid/ready handshake and squashes wrong-path fetches on redirect.

Parameters:
RESET_PC  32'h0000_0000  PC fetched first after reset
DEPTH  2  instruction buffer entries; also the cap on (outstanding + buffered)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
imemReq  output  1  fetch request valid
imemAddr  output  32  fetch address (word aligned)
imemGnt  input  1  request accepted this cycle when imemReq=1
imemRvalid  input  1  response word valid
imemRdata  input  32  response word
redirect  input  1  taken branch/jump (pcSrc from control unit)
redirectPc  input  32  redirect target
instrValid  output  1  head instruction valid
instrReady  input  1  downstream consumes head
instr  output  32  head instruction word
instrPc  output  32  PC of head instruction
instrPcPlus4  output  32  instrPc + 4
op  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  1  instr[30]

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, buffer empty, outstanding=0, discard=0.
  - imemReq=0 and instrValid=0 while rst_n=0.
  - All data outputs are 0 while empty.
- Request issue:
  - imemReq = (outstanding + occupancy < DEPTH) & !redirect. This credit scheme means a response always has buffer space.
  - imemAddr = pc. It is held stable while imemReq & !imemGnt.
  - On imemReq & imemGnt: pc <= pc+4 (32-bit wrap: 0xFFFF_FFFC -> 0). The issued address is pushed to an internal in-flight address queue (depth DEPTH), and outstanding is incremented.
- Response:
  - Responses are returned in order, no earlier than the cycle after the grant.
  - On imemRvalid:
    - If discard>0, the word is dropped and discard decrements.
    - Otherwise the word and the head of the in-flight queue are pushed into the buffer.
    - In both cases outstanding decrements.
  - imemRvalid with outstanding==0 is ignored.
- Output:
  - instrValid = buffer not empty. Outputs come from the buffer head; the buffer is registered with no bypass.
  - Minimum latency is rvalid cycle -> instrValid the next cycle.
  - Pop on instrValid & instrReady.
  - Outputs stay stable while instrValid & !instrReady.
- Redirect (highest priority):
  - A pop occurring in the redirect cycle completes; that is the branch itself.
  - Every other buffered entry is flushed.
  - discard <= outstanding after this cycle's response and grant accounting. Any response arriving in the redirect cycle is dropped.
  - pc <= {redirectPc[31:2],2'b00}. imemReq is 0 in the redirect cycle and rises the next cycle with imemAddr = new pc.
  - Redirect while discard>0 adds to discard. Redirect with an empty buffer is legal.
- Simultaneous push and pop in the same cycle: occupancy is unchanged, order is preserved.
- Counters are saturation-free by construction. outstanding, discard and occupancy are each ≤ DEPTH; an assertion checks this.

Test Plan:
- Reset then release; memory grants every cycle with 1-cycle latency; instrReady=1 -> imemAddr 0,4,8,...; instrPc follows with pc of word N visible 2 cycles after its grant; no gaps once pipeline is full.
- Backpressure: instrReady=0 for 5 cycles -> at most DEPTH(2) requests issued, imemReq drops, instr/instrPc held; release -> words in order, no loss or duplicate.
- Redirect with 2 outstanding, target 0x100 -> the next 2 responses are dropped, buffer is flushed, first accepted instr has instrPc=0x100.
- Redirect concurrent with rvalid and pop -> the popped entry completes, the arriving word is dropped, imemReq=0 that cycle, next imemAddr=0x100.
- Redirect target 0x103 -> imemAddr=0x100; PC wrap: pc=0xFFFF_FFFC grant -> next imemAddr=0.
- Assert rst_n low mid-stream with 2 outstanding -> outputs clear immediately; after release the first fetch is RESET_PC; op/funct3/funct7 equal the instr slices for the word 0x00A50533 (op=0x33, funct3=0, funct7=0).

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Purpose: bundles the signals between the fetch stage, instruction memory,
// the control unit and the downstream decode stage.
// Ports (no direct ports; signals grouped by modport):
//   master (fetch_unit side):
//     out: imemReq, imemAddr[31:0], instrValid, instr[31:0], instrPc[31:0],
//          instrPcPlus4[31:0], op[6:0], funct3[2:0], funct7
//     in:  imemGnt, imemRvalid, imemRdata[31:0], redirect, redirectPc[31:0],
//          instrReady
//   slave (environment side): the same signals with directions reversed.
interface fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic [31:0] instrPcPlus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;

  modport master (
    output imemReq, imemAddr, instrValid, instr, instrPc, instrPcPlus4,
           op, funct3, funct7,
    input  imemGnt, imemRvalid, imemRdata, redirect, redirectPc, instrReady
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, instrPc, instrPcPlus4,
           op, funct3, funct7,
    output imemGnt, imemRvalid, imemRdata, redirect, redirectPc, instrReady
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Purpose: instruction fetch stage. Owns the PC, issues variable-latency
// requests to instruction memory, buffers returned words in a small in-order
// FIFO and hands them to decode over a valid/ready handshake. A redirect
// (taken branch/jump) squashes everything fetched down the wrong path.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    fetch_unit_if.master: imem request/grant/response, redirect,
//          and the decoded head-of-buffer outputs
// Parameters:
//   RESET_PC  first PC fetched after reset
//   DEPTH     buffer entries; also the cap on outstanding + buffered words
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_unit_if.master  bus
);

  localparam int                CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] occupancy;

  // Entry 0 is always the head in both shift-style queues.
  logic [31:0] fifo_instr    [DEPTH];
  logic [31:0] fifo_pc       [DEPTH];
  logic [31:0] inflight_addr [DEPTH];

  logic             credit_ok;
  logic             grant;
  logic             rsp;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_valid;
  logic [31:0]      head_instr;
  logic [31:0]      head_pc;
  logic [31:0]      pc_next;
  logic [CNT_W-1:0] out_next;
  logic [CNT_W-1:0] disc_next;
  logic [CNT_W-1:0] occ_next;
  logic [CNT_W-1:0] fifo_wr_idx;
  logic [CNT_W-1:0] inflight_wr_idx;
  logic [CNT_W:0]   credit_used;

  // Credits count both in-flight and buffered words, so every response is
  // guaranteed a free buffer slot. rst_n gates the request so nothing is
  // issued while reset is held.
  assign credit_used = {1'b0, outstanding} + {1'b0, occupancy};
  assign credit_ok   = credit_used < {1'b0, DEPTH_C};
  assign bus.imemReq  = credit_ok & ~bus.redirect & rst_n;
  assign bus.imemAddr = pc;

  assign grant      = bus.imemReq & bus.imemGnt;
  assign rsp        = bus.imemRvalid & (outstanding != '0);
  assign head_valid = (occupancy != '0);
  assign fifo_pop   = head_valid & bus.instrReady;
  // A response is kept only if it is not wrong-path and no redirect is
  // happening this cycle.
  assign fifo_push  = rsp & (discard == '0) & ~bus.redirect;

  assign fifo_wr_idx     = occupancy - CNT_W'(fifo_pop);
  assign inflight_wr_idx = outstanding - CNT_W'(rsp);

  // Next-state counters. On redirect every request still outstanding after
  // this cycle's accounting belongs to the wrong path, which also covers any
  // discards already pending.
  always_comb begin
    out_next  = outstanding + CNT_W'(grant) - CNT_W'(rsp);
    disc_next = discard;
    occ_next  = occupancy + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    pc_next   = pc;
    if (grant) begin
      pc_next = pc + 32'd4;
    end
    if (rsp && (discard != '0)) begin
      disc_next = discard - CNT_W'(1);
    end
    if (bus.redirect) begin
      disc_next = out_next;
      occ_next  = '0;
      pc_next   = bus.redirectPc & 32'hFFFF_FFFC;
    end
  end

  // State registers and the two shift queues. A pop shifts entries toward
  // the head; a push lands just behind the last surviving entry, so a
  // simultaneous push and pop keeps order and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      occupancy   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i]    <= '0;
        fifo_pc[i]       <= '0;
        inflight_addr[i] <= '0;
      end
    end else begin
      pc          <= pc_next;
      outstanding <= out_next;
      discard     <= disc_next;
      occupancy   <= occ_next;
      if (rsp) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          inflight_addr[i] <= inflight_addr[i+1];
        end
      end
      if (grant) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == inflight_wr_idx) begin
            inflight_addr[i] <= pc;
          end
        end
      end
      if (fifo_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          fifo_instr[i] <= fifo_instr[i+1];
          fifo_pc[i]    <= fifo_pc[i+1];
        end
      end
      if (fifo_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == fifo_wr_idx) begin
            fifo_instr[i] <= bus.imemRdata;
            fifo_pc[i]    <= inflight_addr[0];
          end
        end
      end
    end
  end

  // Stale buffer contents are masked so every data output reads 0 when empty.
  assign head_instr = head_valid ? fifo_instr[0] : 32'h0;
  assign head_pc    = head_valid ? fifo_pc[0]    : 32'h0;

  assign bus.instrValid   = head_valid;
  assign bus.instr        = head_instr;
  assign bus.instrPc      = head_pc;
  assign bus.instrPcPlus4 = head_valid ? head_pc + 32'd4 : 32'h0;
  assign bus.op           = head_instr[6:0];
  assign bus.funct3       = head_instr[14:12];
  assign bus.funct7       = head_instr[30];

  counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    (outstanding <= DEPTH_C) && (discard <= outstanding) &&
    (occupancy <= DEPTH_C) && (credit_used <= {1'b0, DEPTH_C}));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Purpose: self-checking bench for fetch_unit. A queue-based model tracks
// the architectural view (requests in flight with a wrong-path flag, the
// buffered instruction stream, the fetch PC) and every cycle the DUT outputs
// are compared against it under directed and randomized stimulus.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  typedef struct {
    logic [31:0] addr;
    bit          wrong;
    int          gcycle;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          assert_count = 0;
  int          fail_count   = 0;
  int          cycle        = 0;
  bit          in_reset;
  logic [31:0] m_pc;
  req_t        inflight [$];
  ent_t        fifo [$];
  bit          cur_gnt;
  bit          cur_ready;
  bit          cur_redirect;
  logic [31:0] cur_target;

  // Memory contents: the word at RESET_PC is a known R-type instruction,
  // everything else is an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h00A5_0533;
    return {a[15:0] ^ 16'h5A3C, a[17:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model says this cycle.
  task automatic checkOutput();
    bit          e_req;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    e_req   = !in_reset && (inflight.size() + fifo.size() < DEPTH) &&
              !cur_redirect;
    e_valid = fifo.size() > 0;
    e_instr = e_valid ? fifo[0].word : 32'h0;
    e_pc    = e_valid ? fifo[0].pc : 32'h0;
    check("imemReq",      32'(bus.imemReq),    32'(e_req));
    check("imemAddr",     bus.imemAddr,        m_pc);
    check("instrValid",   32'(bus.instrValid), 32'(e_valid));
    check("instr",        bus.instr,           e_instr);
    check("instrPc",      bus.instrPc,         e_pc);
    check("instrPcPlus4", bus.instrPcPlus4,    e_valid ? e_pc + 32'd4 : 32'h0);
    check("op",           32'(bus.op),         32'(e_instr[6:0]));
    check("funct3",       32'(bus.funct3),     32'(e_instr[14:12]));
    check("funct7",       32'(bus.funct7),     32'(e_instr[30]));
  endtask

  // Advance the model by one clock using the rules of the fetch stage.
  task automatic updateModel(input bit rsp_sent);
    bit   grant;
    bit   pop;
    req_t r;
    grant = !in_reset && (inflight.size() + fifo.size() < DEPTH) &&
            !cur_redirect && cur_gnt;
    pop   = (fifo.size() > 0) && cur_ready;
    if (pop) void'(fifo.pop_front());
    if (rsp_sent) begin
      r = inflight.pop_front();
      if (!r.wrong && !cur_redirect) fifo.push_back('{r.addr, mem_word(r.addr)});
    end
    if (grant) begin
      inflight.push_back('{m_pc, 1'b0, cycle});
      m_pc = m_pc + 32'd4;
    end
    if (cur_redirect) begin
      fifo.delete();
      foreach (inflight[i]) inflight[i].wrong = 1'b1;
      m_pc = cur_target & 32'hFFFF_FFFC;
    end
    cycle++;
  endtask

  // One cycle: drive inputs at the falling edge (memory answers the oldest
  // request if allowed and at least a cycle old), check, advance the model.
  task automatic applyStimulus(input bit gnt, input bit ready, input bit redir,
                               input logic [31:0] target, input bit resp_en,
                               input bit spurious);
    bit sent;
    @(negedge clk);
    cur_gnt        = gnt;
    cur_ready      = ready;
    cur_redirect   = redir;
    cur_target     = target;
    bus.imemGnt    = gnt;
    bus.instrReady = ready;
    bus.redirect   = redir;
    bus.redirectPc = target;
    sent = 1'b0;
    if (resp_en && inflight.size() > 0 && inflight[0].gcycle < cycle) begin
      bus.imemRvalid = 1'b1;
      bus.imemRdata  = mem_word(inflight[0].addr);
      sent = 1'b1;
    end else if (spurious && inflight.size() == 0) begin
      bus.imemRvalid = 1'b1;
      bus.imemRdata  = $urandom;
    end else begin
      bus.imemRvalid = 1'b0;
      bus.imemRdata  = $urandom;
    end
    #1;
    checkOutput();
    updateModel(sent);
  endtask

  task automatic normalCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic resetDut();
    @(negedge clk);
    bus.imemGnt    = 1'b0;
    bus.imemRvalid = 1'b0;
    bus.redirect   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    in_reset     = 1'b1;
    cur_redirect = 1'b0;
    inflight.delete();
    fifo.delete();
    m_pc = RESET_PC;
    check("rstReq",   32'(bus.imemReq),    32'h0);
    check("rstValid", 32'(bus.instrValid), 32'h0);
    check("rstInstr", bus.instr,           32'h0);
    check("rstPc",    bus.instrPc,         32'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
  endtask

  initial begin
    bit done;
    rst_n          = 1'b0;
    in_reset       = 1'b1;
    m_pc           = RESET_PC;
    bus.imemGnt    = 1'b0;
    bus.imemRvalid = 1'b0;
    bus.imemRdata  = 32'h0;
    bus.redirect   = 1'b0;
    bus.redirectPc = 32'h0;
    bus.instrReady = 1'b0;
    cur_gnt = 1'b0; cur_ready = 1'b0; cur_redirect = 1'b0; cur_target = 32'h0;

    $display("[TB] reset and streaming");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_reset = 1'b0;
    repeat (20) normalCycle();

    $display("[TB] backpressure");
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (10) normalCycle();

    $display("[TB] spurious response while idle");
    drain();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    $display("[TB] redirect with two outstanding");
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
    repeat (12) normalCycle();

    $display("[TB] redirect concurrent with response and pop");
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (fifo.size() > 0 && inflight.size() > 0 && inflight[0].gcycle < cycle) begin
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0);
        done = 1'b1;
      end else begin
        normalCycle();
      end
    end
    check("concurrentSeen", 32'(done), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("redirAddr", bus.imemAddr, 32'h100);
    repeat (10) normalCycle();

    $display("[TB] misaligned target and PC wrap");
    drain();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h103, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    check("alignAddr", bus.imemAddr, 32'h100);
    check("alignReq",  32'(bus.imemReq), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    normalCycle();
    check("wrapHi", bus.imemAddr, 32'hFFFF_FFFC);
    normalCycle();
    check("wrapLo", bus.imemAddr, 32'h0);
    repeat (6) normalCycle();

    $display("[TB] randomized traffic");
    repeat (400) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) == 0, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] reset mid-stream");
    drain();
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    resetDut();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("firstPc",    bus.instrPc,         RESET_PC);
    check("firstInstr", bus.instr,           32'h00A5_0533);
    check("firstOp",    32'(bus.op),         32'h33);
    check("firstF3",    32'(bus.funct3),     32'h0);
    check("firstF7",    32'(bus.funct7),     32'h0);
    repeat (8) normalCycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
